m_lsu: RTL
==========

Name: m_lsu

Overview:
- Memory-stage load/store unit: the initiator side of the data-memory port.
- Takes M-stage load/store requests and issues word-aligned, byte-enabled requests to the data memory over a req/ack handshake.
- Stalls the pipeline until the access completes and returns aligned, sign- or zero-extended load data.
- Detects misaligned accesses and access timeouts and reports them as exceptions.

Parameters:
TIMEOUT, 16, maximum cycles the unit waits for mem_ack before aborting with bus error (≥2)
ADDR_W, 32, byte address width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
op_valid  in  1  M stage holds a load/store this cycle
op  in  3  0=LW 1=LH 2=LHU 3=LB 4=LBU 5=SW 6=SH 7=SB
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data (rt value), low bits significant for SH/SB
pc  in  32  PC of the instruction, for exception reporting
mem_req  out  1  request to data memory
mem_we  out  1  1=write, 0=read
mem_addr  out  ADDR_W  word-aligned address, low 2 bits forced 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-positioned write data
mem_ack  in  1  memory completes request this cycle
mem_rdata  in  32  read word, valid with mem_ack
stall  out  1  freeze F/D/E/M stages
ld_valid  out  1  ld_data valid (one cycle)
ld_data  out  32  extended load result
exc_valid  out  1  exception pulse (one cycle)
exc_code  out  2  1=misaligned load, 2=misaligned store, 3=bus timeout
exc_pc  out  32  PC of faulting instruction

Behaviour:
- Reset (reset=0, async): state=IDLE; all outputs 0; timeout counter 0. Any in-flight request is abandoned, and an ack arriving after reset is ignored.
- FSM states: IDLE, WAIT, DONE.
- stall = op_valid & (state != DONE). Combinational, so stall rises in the same cycle op_valid rises.
- IDLE, op_valid=1: latch op/addr/wdata/pc.
  - Misaligned (LW/SW with addr[1:0]≠0; LH/LHU/SH with addr[0]=1): no memory request; go to DONE with exc pending.
  - Otherwise: go to WAIT with mem_req=1 registered; mem_addr, mem_we, mem_be and mem_wdata are driven from the latched values.
- Byte enables and write data:
  - SW: be=1111, data as-is.
  - SH: be=0011 if addr[1]=0, else 1100; wdata[15:0] replicated to both halves.
  - SB: be=0001<<addr[1:0]; wdata[7:0] replicated to all four bytes.
  - Loads: be=1111, mem_we=0.
- WAIT: mem_req and its fields held stable until mem_ack.
  - mem_ack=1: mem_req drops next cycle; for loads, capture the extracted data; go to DONE.
  - Counter increments each WAIT cycle without ack. On reaching TIMEOUT-1 with no ack: abort, code 3, go to DONE.
  - An ack in the same cycle as the timeout takes priority (completes normally).
- Load extraction from the latched address:
  - LB/LBU: byte addr[1:0] (byte 0 = bits 7:0), sign/zero-extended.
  - LH/LHU: half addr[1], sign/zero-extended.
  - LW: the full word.
- DONE, one cycle:
  - stall=0.
  - ld_valid=1 for a successful load.
  - exc_valid=1 with exc_code and exc_pc if a fault occurred; ld_valid=0 on any fault.
  - Then go to IDLE.
  - A new op_valid in DONE is the next instruction; it is taken in the following IDLE cycle. Minimum access is therefore 3 cycles (IDLE→WAIT→DONE) with a zero-wait ack.
- op_valid dropping during WAIT: the access still completes; no cancellation.
- mem_ack outside WAIT: ignored.
- Address wrap: none; mem_addr = {addr[ADDR_W-1:2],2'b00}.

Test Plan:
- Reset → all outputs 0, state IDLE. Assert reset low mid-WAIT → mem_req drops in the same cycle asynchronously; a later ack produces no ld_valid.
- SB addr=0x0000_1003, wdata=0x1234_56AB, ack after 2 cycles → mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000; stall high for 4 cycles then low.
- LB addr=0x2, mem_rdata=0x0080_0000 → ld_data=0xFFFF_FF80. LBU at the same address → ld_data=0x0000_0080. LH addr=0x2, rdata=0x8001_0000 → ld_data=0xFFFF_8001.
- LW addr=0x6, pc=0x3010 → no mem_req; one-cycle exc_valid with exc_code=1, exc_pc=0x3010. SH addr=0x5 → exc_code=2.
- Load with mem_ack never asserted, TIMEOUT=16 → exc_code=3 in DONE after 16 WAIT cycles; mem_req deasserted; ld_valid=0.
- Back-to-back SW then LW, zero-wait acks → each completes in 3 cycles; the LW returns the stored word (memory model check).

Source files
------------

// File: rtl/m_lsu.sv
// Memory-stage load/store unit: issues byte-enabled word requests to data memory,
// stalls the pipeline until completion, extends load data and reports faults.
module m_lsu #(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned ADDR_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              op_valid_i,
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic [31:0]       pc_i,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_be_o,
   output logic [31:0]       mem_wdata_o,
   input  logic              mem_ack_i,
   input  logic [31:0]       mem_rdata_i,
   output logic              stall_c_o,
   output logic              ld_valid_o,
   output logic [31:0]       ld_data_o,
   output logic              exc_valid_o,
   output logic [1:0]        exc_code_o,
   output logic [31:0]       exc_pc_o
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LH  = 3'd1;
   localparam logic [2:0] OP_LHU = 3'd2;
   localparam logic [2:0] OP_LB  = 3'd3;
   localparam logic [2:0] OP_LBU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SH  = 3'd6;
   localparam logic [2:0] OP_SB  = 3'd7;

   localparam logic [1:0] EXC_MIS_LD  = 2'd1;
   localparam logic [1:0] EXC_MIS_ST  = 2'd2;
   localparam logic [1:0] EXC_TIMEOUT = 2'd3;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [1:0]          lo_q, lo_d;
   logic [31:0]         pc_q, pc_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]          mem_be_q, mem_be_d;
   logic [31:0]         mem_wdata_q, mem_wdata_d;
   logic                ld_valid_q, ld_valid_d;
   logic [31:0]         ld_data_q, ld_data_d;
   logic                exc_valid_q, exc_valid_d;
   logic [1:0]          exc_code_q, exc_code_d;
   logic [31:0]         exc_pc_q, exc_pc_d;

   logic                is_store_c;
   logic                misal_c;
   logic [3:0]          be_c;
   logic [31:0]         wdata_c;
   logic [7:0]          rd_byte_c;
   logic [15:0]         rd_half_c;
   logic [31:0]         ld_ext_c;

   // Decode the incoming request: alignment, lane enables and lane-replicated data
   always_comb begin
      is_store_c = (op_i == OP_SW) || (op_i == OP_SH) || (op_i == OP_SB);
      misal_c    = 1'b0;
      be_c       = 4'b1111;
      wdata_c    = wdata_i;
      case (op_i)
         OP_LW, OP_SW:         misal_c = (addr_i[1:0] != 2'b00);
         OP_LH, OP_LHU:        misal_c = addr_i[0];
         OP_SH: begin
            misal_c = addr_i[0];
            be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_c = {wdata_i[15:0], wdata_i[15:0]};
         end
         OP_SB: begin
            be_c    = 4'b0001 << addr_i[1:0];
            wdata_c = {4{wdata_i[7:0]}};
         end
         default: ;
      endcase
   end

   // Pick the addressed lane of the returned word and extend it
   always_comb begin
      case (lo_q)
         2'd0:    rd_byte_c = mem_rdata_i[7:0];
         2'd1:    rd_byte_c = mem_rdata_i[15:8];
         2'd2:    rd_byte_c = mem_rdata_i[23:16];
         default: rd_byte_c = mem_rdata_i[31:24];
      endcase
      rd_half_c = lo_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (op_q)
         OP_LH:   ld_ext_c = {{16{rd_half_c[15]}}, rd_half_c};
         OP_LHU:  ld_ext_c = {16'h0000, rd_half_c};
         OP_LB:   ld_ext_c = {{24{rd_byte_c[7]}}, rd_byte_c};
         OP_LBU:  ld_ext_c = {24'h000000, rd_byte_c};
         default: ld_ext_c = mem_rdata_i;
      endcase
   end

   assign stall_c_o = op_valid_i & (state_q != S_DONE);

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lo_d        = lo_q;
      pc_d        = pc_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      ld_valid_d  = 1'b0;
      ld_data_d   = ld_data_q;
      exc_valid_d = 1'b0;
      exc_code_d  = exc_code_q;
      exc_pc_d    = exc_pc_q;
      case (state_q)
         S_IDLE: begin
            if (op_valid_i) begin
               op_d        = op_i;
               lo_d        = addr_i[1:0];
               pc_d        = pc_i;
               mem_we_d    = is_store_c;
               mem_addr_d  = {addr_i[ADDR_W-1:2], 2'b00};
               mem_be_d    = be_c;
               mem_wdata_d = wdata_c;
               if (misal_c) begin
                  exc_valid_d = 1'b1;
                  exc_code_d  = is_store_c ? EXC_MIS_ST : EXC_MIS_LD;
                  exc_pc_d    = pc_i;
                  state_d     = S_DONE;
               end else begin
                  mem_req_d = 1'b1;
                  cnt_d     = '0;
                  state_d   = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // An ack coinciding with the last allowed cycle still completes normally
            if (mem_ack_i) begin
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  ld_valid_d = 1'b1;
                  ld_data_d  = ld_ext_c;
               end
               state_d = S_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
               mem_req_d   = 1'b0;
               exc_valid_d = 1'b1;
               exc_code_d  = EXC_TIMEOUT;
               exc_pc_d    = pc_q;
               state_d     = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         lo_q        <= '0;
         pc_q        <= '0;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         ld_valid_q  <= 1'b0;
         ld_data_q   <= '0;
         exc_valid_q <= 1'b0;
         exc_code_q  <= '0;
         exc_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         lo_q        <= lo_d;
         pc_q        <= pc_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         ld_valid_q  <= ld_valid_d;
         ld_data_q   <= ld_data_d;
         exc_valid_q <= exc_valid_d;
         exc_code_q  <= exc_code_d;
         exc_pc_q    <= exc_pc_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_be_o    = mem_be_q;
   assign mem_wdata_o = mem_wdata_q;
   assign ld_valid_o  = ld_valid_q;
   assign ld_data_o   = ld_data_q;
   assign exc_valid_o = exc_valid_q;
   assign exc_code_o  = exc_code_q;
   assign exc_pc_o    = exc_pc_q;

endmodule
